// File: rtl/hazard_int_ctrl_pkg.sv
// Shared definitions for the hazard/interrupt sequencer: next-PC selects,
// FSM encoding and interrupt geometry.
package hazard_int_ctrl_pkg;

    localparam int          NUM_IRQ      = 3;
    localparam int          IRQ_IDX_W    = 2;
    localparam logic [31:0] DEF_VEC_BASE = 32'h0000_0100;

    localparam logic [1:0] PCSEL_SEQ = 2'd0;
    localparam logic [1:0] PCSEL_BR  = 2'd1;
    localparam logic [1:0] PCSEL_VEC = 2'd2;
    localparam logic [1:0] PCSEL_EPC = 2'd3;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_ENTER   = 2'd1,
        ST_SERVICE = 2'd2,
        ST_RETURN  = 2'd3
    } state_e;

    // Handler n lives four words above handler n-1.
    function automatic logic [31:0] vec_addr(input logic [31:0]          base,
                                             input logic [IRQ_IDX_W-1:0] idx);
        return base + {{(30-IRQ_IDX_W){1'b0}}, idx, 2'b00};
    endfunction

endpackage

// File: rtl/hazard_int_ctrl_irq_pending.sv
// Edge-detects the level irq lines into a pending latch and picks the
// lowest pending index.
module hazard_int_ctrl_irq_pending
    import hazard_int_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_IRQ-1:0]   irq,
    input  logic [NUM_IRQ-1:0]   irq_ack,
    output logic                 any_pend,
    output logic [IRQ_IDX_W-1:0] pend_idx
);

    logic [NUM_IRQ-1:0] irq_prev_q, irq_prev_d;
    logic [NUM_IRQ-1:0] pend_q, pend_d;
    logic [NUM_IRQ-1:0] rise;

    always_comb begin
        rise       = irq & ~irq_prev_q;
        irq_prev_d = irq;
        // A new edge wins over an acknowledge landing in the same cycle.
        pend_d     = (pend_q & ~irq_ack) | rise;
        // Counting this cycle's edge lets entry coincide with the pend latch.
        any_pend   = |(pend_q | rise);
    end

    always_comb begin
        pend_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pend_q[i]) pend_idx = IRQ_IDX_W'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_prev_q <= '0;
            pend_q     <= '0;
        end else begin
            irq_prev_q <= irq_prev_d;
            pend_q     <= pend_d;
        end
    end

endmodule

// File: rtl/hazard_int_ctrl.sv
// Load-use stall, branch redirect and single-level interrupt entry/return
// sequencing for the 5-stage core.
module hazard_int_ctrl
    import hazard_int_ctrl_pkg::*;
#(
    parameter logic [31:0] VEC_BASE = DEF_VEC_BASE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [4:0]           id_ra,
    input  logic [4:0]           id_rb,
    input  logic                 id_uses_ra,
    input  logic                 id_uses_rb,
    input  logic                 id_valid,
    input  logic [31:0]          id_pc,
    input  logic                 id_eret,
    input  logic [4:0]           ex_dst,
    input  logic                 ex_regwrite,
    input  logic                 ex_memtoreg,
    input  logic                 ex_redirect,
    input  logic [NUM_IRQ-1:0]   irq,
    input  logic                 irq_en,
    output logic                 stall,
    output logic                 flush_ifid,
    output logic                 flush_idex,
    output logic [1:0]           pc_sel,
    output logic [31:0]          vector,
    output logic [31:0]          epc,
    output logic [IRQ_IDX_W-1:0] cause,
    output logic                 int_active,
    output logic [NUM_IRQ-1:0]   irq_ack,
    output state_e               state_dbg
);

    state_e               state_q, state_d;
    logic [31:0]          epc_q, epc_d;
    logic [IRQ_IDX_W-1:0] cause_q, cause_d;
    logic                 any_pend;
    logic [IRQ_IDX_W-1:0] pend_idx;
    logic                 lu;

    hazard_int_ctrl_irq_pending u_irq_pending (
        .clk      (clk),
        .rst_n    (rst_n),
        .irq      (irq),
        .irq_ack  (irq_ack),
        .any_pend (any_pend),
        .pend_idx (pend_idx)
    );

    // The MEM-stage load result cannot be forwarded, so a dependent ID op waits.
    assign lu = ex_regwrite & ex_memtoreg & (ex_dst != 5'd0) &
                ((id_uses_ra & (id_ra == ex_dst)) | (id_uses_rb & (id_rb == ex_dst)));

    always_comb begin
        state_d    = state_q;
        epc_d      = epc_q;
        cause_d    = cause_q;
        stall      = 1'b0;
        flush_ifid = 1'b0;
        flush_idex = 1'b0;
        pc_sel     = PCSEL_SEQ;
        int_active = 1'b0;
        irq_ack    = '0;
        vector     = vec_addr(VEC_BASE, cause_q);

        unique case (state_q)
            ST_RUN, ST_SERVICE: begin
                if (ex_redirect) begin
                    pc_sel     = PCSEL_BR;
                    flush_ifid = 1'b1;
                    flush_idex = 1'b1;
                end else if (lu) begin
                    stall      = 1'b1;
                    flush_idex = 1'b1;
                end
                if (state_q == ST_RUN) begin
                    if (irq_en && any_pend && id_valid && !lu && !ex_redirect)
                        state_d = ST_ENTER;
                end else begin
                    int_active = 1'b1;
                    if (id_eret && !lu && !ex_redirect) state_d = ST_RETURN;
                end
            end
            ST_ENTER: begin
                // The ID instruction is flushed and replayed from epc on return.
                epc_d      = id_pc;
                cause_d    = pend_idx;
                irq_ack    = {{(NUM_IRQ-1){1'b0}}, 1'b1} << pend_idx;
                vector     = vec_addr(VEC_BASE, pend_idx);
                pc_sel     = PCSEL_VEC;
                flush_ifid = 1'b1;
                flush_idex = 1'b1;
                state_d    = ST_SERVICE;
            end
            ST_RETURN: begin
                pc_sel     = PCSEL_EPC;
                flush_ifid = 1'b1;
                int_active = 1'b1;
                state_d    = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            epc_q   <= '0;
            cause_q <= '0;
        end else begin
            state_q <= state_d;
            epc_q   <= epc_d;
            cause_q <= cause_d;
        end
    end

    assign epc       = epc_q;
    assign cause     = cause_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_hazard_int_ctrl.sv
// Directed scoreboard bench for hazard_int_ctrl: drivers push the expected
// output bundle per cycle, a negedge monitor pops and compares.
module tb_hazard_int_ctrl;
  import hazard_int_ctrl_pkg::*;

  localparam int W = 77;

  logic        clk;
  logic        rst_n;
  logic [4:0]  id_ra, id_rb, ex_dst;
  logic        id_uses_ra, id_uses_rb, id_valid, id_eret;
  logic [31:0] id_pc;
  logic        ex_regwrite, ex_memtoreg, ex_redirect;
  logic [2:0]  irq;
  logic        irq_en;
  logic        stall, flush_ifid, flush_idex;
  logic [1:0]  pc_sel;
  logic [31:0] vector, epc;
  logic [1:0]  cause;
  logic        int_active;
  logic [2:0]  irq_ack;
  state_e      state_dbg;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           checks = 0;
  int           errors = 0;

  hazard_int_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .id_ra(id_ra), .id_rb(id_rb), .id_uses_ra(id_uses_ra), .id_uses_rb(id_uses_rb),
    .id_valid(id_valid), .id_pc(id_pc), .id_eret(id_eret),
    .ex_dst(ex_dst), .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg),
    .ex_redirect(ex_redirect), .irq(irq), .irq_en(irq_en),
    .stall(stall), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
    .pc_sel(pc_sel), .vector(vector), .epc(epc), .cause(cause),
    .int_active(int_active), .irq_ack(irq_ack), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] mk(input logic st, input logic fi, input logic fd,
                                      input logic [1:0] ps, input logic [31:0] vec,
                                      input logic [31:0] ep, input logic [1:0] ca,
                                      input logic act, input logic [2:0] ack,
                                      input logic [1:0] sd);
    return {st, fi, fd, ps, vec, ep, ca, act, ack, sd};
  endfunction

  // driver: inputs are already set; queue the expectation for this cycle
  task automatic drive(input string nm, input logic [W-1:0] e);
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_hazard();
    ex_regwrite = 1'b0; ex_memtoreg = 1'b0; ex_dst = 5'd0; ex_redirect = 1'b0;
    id_uses_ra = 1'b0; id_uses_rb = 1'b0; id_ra = 5'd0; id_rb = 5'd0; id_eret = 1'b0;
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [W-1:0] e, a;
    string nm;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {stall, flush_ifid, flush_idex, pc_sel, vector, epc, cause, int_active,
            irq_ack, 2'(state_dbg)};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got %h expected %h", nm, a, e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; irq = 3'b000; irq_en = 1'b0; id_valid = 1'b0; id_pc = 32'h0;
    clear_hazard();
    repeat (2) @(posedge clk);
    #1;
    drive("reset", mk(0,0,0,PCSEL_SEQ,32'h100,32'h0,2'd0,0,3'b000,ST_RUN));
    rst_n = 1'b1;

    // load-use hazards
    id_valid = 1'b1;
    ex_regwrite = 1'b1; ex_memtoreg = 1'b1; ex_dst = 5'd5; id_ra = 5'd5; id_uses_ra = 1'b1;
    drive("lu_ra", mk(1,0,1,PCSEL_SEQ,32'h100,32'h0,2'd0,0,3'b000,ST_RUN));
    ex_regwrite = 1'b0; ex_memtoreg = 1'b0;
    drive("lu_one_cycle", mk(0,0,0,PCSEL_SEQ,32'h100,32'h0,2'd0,0,3'b000,ST_RUN));
    ex_regwrite = 1'b1; ex_memtoreg = 1'b1; ex_dst = 5'd0; id_ra = 5'd0;
    drive("lu_dst0", mk(0,0,0,PCSEL_SEQ,32'h100,32'h0,2'd0,0,3'b000,ST_RUN));
    ex_dst = 5'd7; id_rb = 5'd7; id_uses_rb = 1'b1; id_uses_ra = 1'b0;
    drive("lu_rb", mk(1,0,1,PCSEL_SEQ,32'h100,32'h0,2'd0,0,3'b000,ST_RUN));
    id_uses_rb = 1'b0;
    drive("lu_not_used", mk(0,0,0,PCSEL_SEQ,32'h100,32'h0,2'd0,0,3'b000,ST_RUN));
    id_uses_rb = 1'b1; ex_memtoreg = 1'b0;
    drive("alu_no_stall", mk(0,0,0,PCSEL_SEQ,32'h100,32'h0,2'd0,0,3'b000,ST_RUN));
    ex_memtoreg = 1'b1; ex_redirect = 1'b1;
    drive("redir_over_lu", mk(0,1,1,PCSEL_BR,32'h100,32'h0,2'd0,0,3'b000,ST_RUN));
    clear_hazard();

    // irq[2] entry, squashed eret, real eret
    irq_en = 1'b1; id_pc = 32'h40; irq = 3'b100;
    drive("irq2_rise", mk(0,0,0,PCSEL_SEQ,32'h100,32'h0,2'd0,0,3'b000,ST_RUN));
    drive("enter2", mk(0,1,1,PCSEL_VEC,32'h108,32'h0,2'd0,0,3'b100,ST_ENTER));
    irq = 3'b000; id_pc = 32'h108;
    drive("service2", mk(0,0,0,PCSEL_SEQ,32'h108,32'h40,2'd2,1,3'b000,ST_SERVICE));
    id_eret = 1'b1; ex_redirect = 1'b1;
    drive("eret_squash", mk(0,1,1,PCSEL_BR,32'h108,32'h40,2'd2,1,3'b000,ST_SERVICE));
    ex_redirect = 1'b0;
    drive("eret_ok", mk(0,0,0,PCSEL_SEQ,32'h108,32'h40,2'd2,1,3'b000,ST_SERVICE));
    id_eret = 1'b0;
    drive("return2", mk(0,1,0,PCSEL_EPC,32'h108,32'h40,2'd2,1,3'b000,ST_RETURN));

    // irq[1] and irq[0] together
    irq = 3'b011; id_pc = 32'h80;
    drive("irq01_rise", mk(0,0,0,PCSEL_SEQ,32'h108,32'h40,2'd2,0,3'b000,ST_RUN));
    drive("enter0", mk(0,1,1,PCSEL_VEC,32'h100,32'h40,2'd2,0,3'b001,ST_ENTER));
    irq = 3'b000; id_eret = 1'b1;
    drive("service0_eret", mk(0,0,0,PCSEL_SEQ,32'h100,32'h80,2'd0,1,3'b000,ST_SERVICE));
    id_eret = 1'b0;
    drive("return0", mk(0,1,0,PCSEL_EPC,32'h100,32'h80,2'd0,1,3'b000,ST_RETURN));
    ex_redirect = 1'b1;
    drive("defer_redir", mk(0,1,1,PCSEL_BR,32'h100,32'h80,2'd0,0,3'b000,ST_RUN));
    ex_redirect = 1'b0; id_pc = 32'hC0;
    drive("run_pend1", mk(0,0,0,PCSEL_SEQ,32'h100,32'h80,2'd0,0,3'b000,ST_RUN));
    drive("enter1", mk(0,1,1,PCSEL_VEC,32'h104,32'h80,2'd0,0,3'b010,ST_ENTER));
    irq = 3'b100;
    drive("service1", mk(0,0,0,PCSEL_SEQ,32'h104,32'hC0,2'd1,1,3'b000,ST_SERVICE));

    // asynchronous reset in SERVICE with irq[2] pending
    rst_n = 1'b0; irq = 3'b000;
    exp_q.push_back(mk(0,0,0,PCSEL_SEQ,32'h100,32'h0,2'd0,0,3'b000,ST_RUN));
    name_q.push_back("async_reset");
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive("after_reset", mk(0,0,0,PCSEL_SEQ,32'h100,32'h0,2'd0,0,3'b000,ST_RUN));
    drive("pend_cleared", mk(0,0,0,PCSEL_SEQ,32'h100,32'h0,2'd0,0,3'b000,ST_RUN));

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d queued expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_int_ctrl.md
# hazard_int_ctrl

Pipeline sequencer for the 5-stage word-addressed core. It generates the stall and flush controls for load-use hazards that the forwarding network cannot cover, since the MEM-stage load result is not forwardable. It redirects fetch on taken branches, and runs a fixed-priority 3-source interrupt entry/return state machine that owns the EPC and cause registers. It sits beside the forwarding unit and drives the PC mux and the IF/ID and ID/EX pipeline-register enables and flushes.

## Interface
- VEC_BASE, 32'h0000_0100: word address of the source-0 handler. Source n handler is at VEC_BASE + 4*n.
- clk input 1: system clock, rising edge.
- rst_n input 1: asynchronous, active-low reset.
- id_ra, id_rb input 5 each: source register numbers of the instruction in ID.
- id_uses_ra, id_uses_rb input 1 each: ID instruction actually reads ra / rb.
- id_valid input 1: ID holds a real (non-bubble) instruction.
- id_pc input 32: PC of the ID instruction.
- id_eret input 1: ID instruction is ERET.
- ex_dst input 5: destination register of the EX instruction.
- ex_regwrite, ex_memtoreg input 1 each: EX instruction writes a register / is a load.
- ex_redirect input 1: EX has a taken branch or jump.
- irq input 3: level interrupt lines. Bit 0 has the highest priority.
- irq_en input 1: global interrupt enable.
- stall output 1: hold PC and IF/ID.
- flush_ifid, flush_idex output 1 each: insert a bubble into IF/ID and ID/EX.
- pc_sel output 2: next-PC source. 0 = sequential, 1 = branch target, 2 = vector, 3 = EPC.
- vector output 32: handler address.
- epc output 32: saved return PC.
- cause output 2: number of the source being serviced.
- int_active output 1: a handler is running.
- irq_ack output 3: one-hot, pulses for one cycle on entry.

## Operation
- **Load-use hazard:** lu = ex_regwrite & ex_memtoreg & (ex_dst != 0) & ((id_uses_ra & id_ra == ex_dst) | (id_uses_rb & id_rb == ex_dst)).
  - When lu=1: stall=1 and flush_idex=1 in the same cycle, all combinational.
- **Redirect:** ex_redirect=1 gives pc_sel=1, flush_ifid=1, flush_idex=1, stall=0.
  - Redirect overrides lu, because the ID instruction is squashed anyway.
- **Pending latch:** each cycle, pend[i] is set on a rising edge of irq[i] (registered previous value). It is cleared by irq_ack[i]. A simultaneous set and clear leaves pend[i]=1.
- **FSM states:** RUN, ENTER, SERVICE, RETURN.
  - RUN to ENTER when: irq_en & |pend & id_valid & ~lu & ~ex_redirect. Otherwise stay in RUN; the interrupt is deferred, never dropped.
  - ENTER, lasting one cycle:
    - epc <= id_pc; cause <= lowest set index of pend; irq_ack[cause] = 1.
    - pc_sel=2, vector = VEC_BASE + 4*cause.
    - flush_ifid=1 and flush_idex=1, so the ID instruction is re-executed after return.
    - Go to SERVICE.
  - SERVICE: int_active=1. New pends are latched but not taken (no nesting). Hazard logic operates normally.
    - Go to RETURN when id_eret & ~lu & ~ex_redirect.
    - An ERET squashed by a redirect is ignored.
  - RETURN, lasting one cycle: pc_sel=3, flush_ifid=1, int_active=1. Go to RUN.
- In ENTER and RETURN, the hazard outputs are forced as listed above. lu and ex_redirect are ignored in those states, because their ID/EX contents are being flushed.
- vector is combinational from the cause register in all other states.

## Timing
- **Reset values:** state=RUN, epc=0, cause=0, pend=0, irq history=0, int_active=0, irq_ack=0.
  - With idle inputs during reset: stall=0, flush_*=0, pc_sel=0.
- **Latency:**
  - lu and redirect act in the same cycle (combinational).
  - irq rising edge at cycle t gives pend at t+1. ENTER is at t+1 at the earliest, with pc_sel=2 that cycle, and the handler's first instruction is in IF at t+2.
  - ERET in ID at cycle t gives RETURN at t+1; fetch of EPC happens at t+2.
- **Boundaries:**
  - ex_dst=0 never stalls.
  - Two sources rising in the same cycle: lowest index wins, and the other stays pending.
  - An irq that falls before ENTER remains pending (edge semantics).
  - rst_n asserted mid-ENTER or mid-SERVICE returns to RUN immediately and asynchronously, and clears pend.

## Structure
- Shared core package holds:
  - pc_sel encodings (PCSEL_SEQ/BR/VEC/EPC);
  - FSM state encoding;
  - NUM_IRQ=3;
  - default VEC_BASE.
- One natural sub-module: irq_pending. It does edge detection, the pending latch, and the priority encoder, and outputs any_pend and the encoded index.
- All other logic stays flat.

## Test plan
- EX lw writing $5, ID add reading $5 (ra) → stall=1 and flush_idex=1 for exactly one cycle. With ex_dst=0, no stall.
- ex_redirect=1 together with lu=1 → pc_sel=1, flush_ifid=1, flush_idex=1, stall=0.
- irq[2] rises with id_pc=0x40 and no hazard → next cycle is ENTER with pc_sel=2, vector=0x108, irq_ack=3'b100. Then epc=0x40, cause=2, int_active=1.
- irq[1] and irq[0] rise together → cause=0 on the first entry. After ERET returns, a second entry is taken with cause=1.
- In SERVICE, id_eret together with ex_redirect → remains in SERVICE. A later unblocked ERET → RETURN with pc_sel=3, then RUN and int_active=0.
- rst_n pulsed low during SERVICE → all state and outputs return to reset values asynchronously, and pend is cleared.
